iob_axis2axi_wr: RTL and testbench
==================================

IOB_AXIS2AXI_WR -- requirements
Module: iob_axis2axi_wr

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter AXI_DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter AXI_LEN_W, default 8, awlen width.
REQ-004 SHALL have parameter AXI_ID_W, default 1, ID width.
REQ-005 SHALL have parameter BURST_W, default 4, giving maximum burst length BURST_SIZE = 2^BURST_W words; BURST_W < AXI_LEN_W.
REQ-006 SHALL have port clk_i, input, 1, clock; one clock domain.
REQ-007 SHALL have port cke_i, input, 1, clock enable; when low, all state holds.
REQ-008 SHALL have port arst_n_i, input, 1, reset; asynchronous, active-low.
REQ-009 SHALL have config_in_addr_i (in, AXI_ADDR_W), config_in_length_i (in, AXI_ADDR_W, words), config_in_valid_i (in, 1) and config_in_ready_o (out, 1): the transfer command.
REQ-010 SHALL have axis_in_data_i (in, AXI_DATA_W), axis_in_valid_i (in, 1) and axis_in_ready_o (out, 1): the input stream.
REQ-011 SHALL have the AXI AW ports awaddr_o, awlen_o, awsize_o, awburst_o, awid_o, awlock_o, awcache_o, awqos_o, awvalid_o and awready_i, with standard AXI4 widths.
REQ-012 SHALL have the AXI W ports wdata_o, wstrb_o, wlast_o, wvalid_o and wready_i; the AXI B ports bresp_i (2), bvalid_i and bready_o.
REQ-013 SHALL have port error_o, output, 1, sticky write-error flag.

Function
REQ-014 SHALL drive the constants awsize=2, awburst=1 (INCR), awid=0, awlock=0, awcache=2, awqos=0 and wstrb all-ones.
REQ-015 SHALL implement the FSM states IDLE, CALC, ADDR, DATA and RESP.
REQ-016 SHALL assert config_in_ready_o only in IDLE.
REQ-017 IDLE: on config valid with length 0, SHALL stay in IDLE; with nonzero length, SHALL latch addr/length and go to CALC.
REQ-018 CALC (1 cycle): burst = min(remaining, BURST_SIZE, (0x1000 - addr[11:0])>>2); SHALL register awlen = burst-1, subtract burst from remaining, go to ADDR.
REQ-019 ADDR: SHALL hold awvalid_o high with stable awaddr/awlen until awready_i, then go to DATA.
REQ-020 DATA: SHALL pass stream to W combinationally: wvalid_o = axis_in_valid_i, axis_in_ready_o = wready_i, wdata_o = axis_in_data_i.
REQ-021 SHALL keep axis_in_ready_o and wvalid_o low outside DATA.
REQ-022 SHALL count accepted beats; wlast_o high on the beat where count == awlen; after the last handshake, go to RESP.
REQ-023 RESP: SHALL assert bready_o; on bvalid_i, advance addr by (awlen+1)<<2; remaining 0 -> IDLE, else CALC.
REQ-024 SHALL never issue AW for burst N+1 before B of burst N (one outstanding burst).
REQ-025 SHALL ensure no burst crosses a 4 KiB boundary; addresses are word aligned (addr[1:0] ignored, driven 0).
REQ-026 SHALL apply the boundary clamp only when AXI_ADDR_W >= 13.
REQ-027 SHALL reset the beat counter in CALC; the counter width is BURST_W+1.

Reset
REQ-028 SHALL on arst_n_i low, immediately go to IDLE and clear addr, remaining, awlen, beat count and error_o.
REQ-029 SHALL keep all valid/ready/last outputs low during reset, except config_in_ready_o, which is 1 after reset.
REQ-030 SHALL abandon any in-flight burst on mid-transfer reset without completion; the bench SHALL reset the interconnect too.

Configuration
REQ-031 With IOB_AXIS2AXI_WR_ERR_EN defined: bresp_i != 0 in RESP SHALL set error_o (sticky until reset), discard remaining length and return to IDLE.
REQ-032 Without IOB_AXIS2AXI_WR_ERR_EN: bresp_i SHALL be ignored and error_o tied 0.

Structure
REQ-033 SHALL place the FSM state encodings, the 4 KiB constant and the AXI constant values in package iob_axis2axi_wr_pkg.
REQ-034 SHALL implement the burst-length computation in sub-module iob_axis2axi_wr_len (combinational min of three terms).
REQ-035 SHALL use iob_reg_cear_r-style registers for state, address, remaining length and awlen.

Verification
REQ-036 addr 0x0, len 40, BURST_W=4 -> bursts awlen 15,15,7 at 0x0, 0x40, 0x80; wlast on beats 16,32,40.
REQ-037 addr 0xFF8, len 8 -> bursts awlen 1 at 0xFF8, awlen 5 at 0x1000; no AW crosses 0x1000.
REQ-038 len 0 with config valid -> no AW issued, config_in_ready_o stays 1.
REQ-039 random wready/axis valid/awready stalls -> data order preserved, beat count matches awlen+1 each burst.
REQ-040 ERR_EN, bresp=2 on first of 3 bursts -> error_o=1, return to IDLE, no further AW.
REQ-041 reset asserted during DATA -> next cycle state IDLE, all valids 0, error_o 0.

Source files
------------

// File: rtl/iob_axis2axi_wr_pkg.sv
// Shared FSM encoding and fixed AXI field values for the AXI-Stream to AXI write bridge.
package iob_axis2axi_wr_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    RESP = 3'd4
  } state_t;

  // Bursts must not cross this byte boundary
  localparam logic [12:0] PAGE_BYTES = 13'h1000;

  // Fixed AXI write-address attributes: 4-byte beats, INCR, normal modifiable
  localparam logic [2:0] AXI_SIZE_W32   = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic       AXI_LOCK_VAL   = 1'b0;
  localparam logic [3:0] AXI_CACHE_VAL  = 4'd2;
  localparam logic [3:0] AXI_QOS_VAL    = 4'd0;

endpackage

// File: rtl/iob_axis2axi_wr_len.sv
// Burst length: min(remaining words, max burst, words left before the 4 KiB page end).
module iob_axis2axi_wr_len #(
  parameter int AXI_ADDR_W = 32,
  parameter int BURST_W    = 4
) (
  input  logic [AXI_ADDR_W-1:0] addr_i,
  input  logic [AXI_ADDR_W-1:0] remaining_i,
  output logic [BURST_W:0]      burst_o
);
  import iob_axis2axi_wr_pkg::*;

  localparam logic [AXI_ADDR_W-1:0] BURST_SIZE = AXI_ADDR_W'(2 ** BURST_W);

  logic [AXI_ADDR_W-1:0] page_words;
  logic [AXI_ADDR_W-1:0] cap;
  logic [AXI_ADDR_W-1:0] min_w;
  logic                  unused_addr;

  assign unused_addr = ^addr_i;

  generate
    if (AXI_ADDR_W >= 13) begin : g_page
      logic [12:0] page_bytes;
      assign page_bytes = PAGE_BYTES - {1'b0, addr_i[11:2], 2'b00};
      assign page_words = AXI_ADDR_W'(page_bytes >> 2);
    end else begin : g_nopage
      // Address space smaller than one page: no boundary can be crossed
      assign page_words = BURST_SIZE;
    end
  endgenerate

  // Three-way minimum
  always_comb begin
    cap     = (remaining_i < BURST_SIZE) ? remaining_i : BURST_SIZE;
    min_w   = (page_words < cap) ? page_words : cap;
    burst_o = (BURST_W + 1)'(min_w);
  end

endmodule

// File: rtl/iob_axis2axi_wr.sv
// AXI-Stream to AXI4 write bridge: one outstanding INCR burst at a time, 4 KiB safe.
// Optional macro IOB_AXIS2AXI_WR_ERR_EN: non-OKAY bresp sets sticky error_o and aborts.
module iob_axis2axi_wr #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int BURST_W    = 4
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_n_i,
  input  logic [AXI_ADDR_W-1:0]   config_in_addr_i,
  input  logic [AXI_ADDR_W-1:0]   config_in_length_i,
  input  logic                    config_in_valid_i,
  output logic                    config_in_ready_o,
  input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
  input  logic                    axis_in_valid_i,
  output logic                    axis_in_ready_o,
  output logic [AXI_ADDR_W-1:0]   awaddr_o,
  output logic [AXI_LEN_W-1:0]    awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic [AXI_ID_W-1:0]     awid_o,
  output logic                    awlock_o,
  output logic [3:0]              awcache_o,
  output logic [3:0]              awqos_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [AXI_DATA_W-1:0]   wdata_o,
  output logic [AXI_DATA_W/8-1:0] wstrb_o,
  output logic                    wlast_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic                    error_o
);
  import iob_axis2axi_wr_pkg::*;

  localparam logic [BURST_W:0] ONE_BEAT = (BURST_W + 1)'(1);

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [AXI_ADDR_W-1:0] rem_q;
  logic [AXI_LEN_W-1:0]  awlen_q;
  logic [BURST_W:0]      beat_q;
  logic [BURST_W:0]      burst;
  logic [AXI_ADDR_W-1:0] burst_bytes;
  logic                  last_beat;
  logic                  bad_resp;
  logic                  cmd_go;
  logic                  w_hs;
  logic                  unused_cfg;

  assign unused_cfg = ^config_in_addr_i[1:0];

  iob_axis2axi_wr_len #(
    .AXI_ADDR_W(AXI_ADDR_W),
    .BURST_W   (BURST_W)
  ) u_len (
    .addr_i     (addr_q),
    .remaining_i(rem_q),
    .burst_o    (burst)
  );

  assign cmd_go      = config_in_valid_i && (config_in_length_i != '0);
  assign w_hs        = axis_in_valid_i && wready_i;
  assign last_beat   = (AXI_LEN_W'(beat_q) == awlen_q);
  assign burst_bytes = (AXI_ADDR_W'(awlen_q) + AXI_ADDR_W'(1)) << 2;

  assign awaddr_o  = addr_q;
  assign awlen_o   = awlen_q;
  assign awsize_o  = AXI_SIZE_W32;
  assign awburst_o = AXI_BURST_INCR;
  assign awid_o    = '0;
  assign awlock_o  = AXI_LOCK_VAL;
  assign awcache_o = AXI_CACHE_VAL;
  assign awqos_o   = AXI_QOS_VAL;
  assign wstrb_o   = '1;
  assign wdata_o   = axis_in_data_i;

`ifdef IOB_AXIS2AXI_WR_ERR_EN
  logic error_q;
  assign bad_resp = (bresp_i != 2'b00);
  assign error_o  = error_q;

  // Sticky error flag, set by a non-OKAY write response
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) error_q <= 1'b0;
    else if (cke_i && state_q == RESP && bvalid_i && bad_resp) error_q <= 1'b1;
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp_i;
  assign bad_resp     = 1'b0;
  assign error_o      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= IDLE;
    else if (cke_i) state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d           = state_q;
    config_in_ready_o = 1'b0;
    awvalid_o         = 1'b0;
    wvalid_o          = 1'b0;
    axis_in_ready_o   = 1'b0;
    wlast_o           = 1'b0;
    bready_o          = 1'b0;
    case (state_q)
      IDLE: begin
        config_in_ready_o = 1'b1;
        if (cmd_go) state_d = CALC;
      end
      CALC: state_d = ADDR;
      ADDR: begin
        awvalid_o = 1'b1;
        if (awready_i) state_d = DATA;
      end
      DATA: begin
        wvalid_o        = axis_in_valid_i;
        axis_in_ready_o = wready_i;
        wlast_o         = last_beat;
        if (w_hs && last_beat) state_d = RESP;
      end
      RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) state_d = (bad_resp || rem_q == '0) ? IDLE : CALC;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address, remaining length, awlen and beat counter
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      addr_q  <= '0;
      rem_q   <= '0;
      awlen_q <= '0;
      beat_q  <= '0;
    end else if (cke_i) begin
      case (state_q)
        IDLE: if (cmd_go) begin
          addr_q <= {config_in_addr_i[AXI_ADDR_W-1:2], 2'b00};
          rem_q  <= config_in_length_i;
        end
        CALC: begin
          awlen_q <= AXI_LEN_W'(burst - ONE_BEAT);
          rem_q   <= rem_q - AXI_ADDR_W'(burst);
          beat_q  <= '0;
        end
        DATA: if (w_hs) beat_q <= beat_q + ONE_BEAT;
        RESP: if (bvalid_i) begin
          addr_q <= addr_q + burst_bytes;
          if (bad_resp) rem_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_axis2axi_wr.sv
// Scoreboard bench for iob_axis2axi_wr: expected AW/W items are queued with each command,
// a monitor pops and compares on every AW and W handshake.
module tb_iob_axis2axi_wr;

  logic        clk = 1'b0;
  logic        cke_i, arst_n_i;
  logic [31:0] config_in_addr_i, config_in_length_i;
  logic        config_in_valid_i, config_in_ready_o;
  logic [31:0] axis_in_data_i;
  logic        axis_in_valid_i, axis_in_ready_o;
  logic [31:0] awaddr_o;
  logic [7:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic [0:0]  awid_o;
  logic        awlock_o;
  logic [3:0]  awcache_o, awqos_o;
  logic        awvalid_o, awready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o, wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o, error_o;

  iob_axis2axi_wr #(
    .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_LEN_W(8), .AXI_ID_W(1), .BURST_W(4)
  ) dut (
    .clk_i(clk), .cke_i(cke_i), .arst_n_i(arst_n_i),
    .config_in_addr_i(config_in_addr_i), .config_in_length_i(config_in_length_i),
    .config_in_valid_i(config_in_valid_i), .config_in_ready_o(config_in_ready_o),
    .axis_in_data_i(axis_in_data_i), .axis_in_valid_i(axis_in_valid_i),
    .axis_in_ready_o(axis_in_ready_o),
    .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awid_o(awid_o), .awlock_o(awlock_o), .awcache_o(awcache_o), .awqos_o(awqos_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o), .error_o(error_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic last; } w_t;

  aw_t         exp_aw[$];
  w_t          exp_w[$];
  logic [31:0] stream_q[$];
  int          errors = 0;
  int          checks = 0;
  int          pending = 0;
  int          aw_count = 0;
  logic        stall_en = 1'b0;
  logic        w_block = 1'b0;
  logic        in_rst = 1'b0;
  logic [1:0]  bresp_next = 2'b00;
  logic [31:0] word_n = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Queue the hand-computed burst (address, awlen) plus its data words
  task automatic push_burst(input logic [31:0] a, input int len);
    exp_aw.push_back('{addr: a, len: 8'(len)});
    for (int i = 0; i <= len; i++) begin
      exp_w.push_back('{data: 32'hC0DE_0000 + word_n, last: (i == len)});
      stream_q.push_back(32'hC0DE_0000 + word_n);
      word_n++;
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] len);
    int n;
    @(posedge clk); #1;
    config_in_addr_i   = a;
    config_in_length_i = len;
    config_in_valid_i  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!config_in_ready_o && n < 200);
    checks++;
    if (!config_in_ready_o) begin
      errors++;
      $display("FAIL cmd_accept actual=ready0 required=ready1");
    end
    @(posedge clk); #1;
    config_in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_aw.size() == 0 && exp_w.size() == 0 && pending == 0 &&
                 config_in_ready_o && !bvalid_i) && n < 4000);
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL %s_timeout actual=aw%0d_w%0d_left required=0_left", name,
               exp_aw.size(), exp_w.size());
    end
    chk({name, "_drained"}, 64'(stream_q.size()), 64'd0);
  endtask

  // Interconnect and stream source model
  initial begin
    logic w_hs, aw_hs, b_hs;
    axis_in_valid_i = 1'b0; axis_in_data_i = '0;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
    forever begin
      @(negedge clk);
      w_hs  = axis_in_valid_i && axis_in_ready_o;
      aw_hs = awvalid_o && awready_i;
      b_hs  = bvalid_i && bready_o;
      @(posedge clk); #1;
      if (in_rst) begin
        stream_q.delete();
        pending = 0;
        axis_in_valid_i = 1'b0; bvalid_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0;
      end else begin
        if (w_hs) void'(stream_q.pop_front());
        if (b_hs) pending--;
        if (aw_hs) pending++;
        if (!axis_in_valid_i || w_hs)
          axis_in_valid_i = (stream_q.size() > 0) && (!stall_en || $urandom_range(0, 3) != 0);
        axis_in_data_i = (stream_q.size() > 0) ? stream_q[0] : 32'd0;
        awready_i = !stall_en || ($urandom_range(0, 1) == 1);
        wready_i  = !w_block && (!stall_en || $urandom_range(0, 2) != 0);
        if (!bvalid_i || b_hs) begin
          bvalid_i = (pending > 0) && (!stall_en || $urandom_range(0, 1) == 1);
          bresp_i  = bresp_next;
        end
      end
    end
  end

  // Monitor: compare every AW and W handshake against the scoreboard
  initial begin
    aw_t         ea;
    w_t          ew;
    logic        outstanding;
    logic [7:0]  cur_len;
    int          beats;
    int unsigned end_b;
    outstanding = 1'b0; cur_len = '0; beats = 0;
    forever begin
      @(negedge clk);
      if (!arst_n_i) begin
        outstanding = 1'b0;
        beats = 0;
      end else begin
        if (awvalid_o && awready_i) begin
          aw_count++;
          chk("aw_one_outstanding", 64'(outstanding), 64'd0);
          outstanding = 1'b1;
          cur_len = awlen_o;
          beats = 0;
          end_b = 32'(awaddr_o[11:0]) + (32'(awlen_o) + 1) * 4;
          chk("aw_4k_cross", 64'(end_b <= 32'h1000), 64'd1);
          if (exp_aw.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_unexpected actual=addr0x%0h required=no_aw", awaddr_o);
          end else begin
            ea = exp_aw.pop_front();
            chk("awaddr", 64'(awaddr_o), 64'(ea.addr));
            chk("awlen", 64'(awlen_o), 64'(ea.len));
          end
        end
        if (wvalid_o && wready_i) begin
          beats++;
          if (exp_w.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected actual=0x%0h required=no_beat", wdata_o);
          end else begin
            ew = exp_w.pop_front();
            chk("wdata", 64'(wdata_o), 64'(ew.data));
            chk("wlast", 64'(wlast_o), 64'(ew.last));
          end
          if (wlast_o) chk("burst_beats", 64'(beats), 64'(cur_len) + 64'd1);
        end
        if (bvalid_i && bready_o) outstanding = 1'b0;
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    chk({name, "_cfg_ready"}, 64'(config_in_ready_o), 64'd1);
    chk({name, "_awvalid"}, 64'(awvalid_o), 64'd0);
    chk({name, "_wvalid"}, 64'(wvalid_o), 64'd0);
    chk({name, "_axis_ready"}, 64'(axis_in_ready_o), 64'd0);
    chk({name, "_wlast"}, 64'(wlast_o), 64'd0);
    chk({name, "_bready"}, 64'(bready_o), 64'd0);
    chk({name, "_error"}, 64'(error_o), 64'd0);
  endtask

  initial begin
    int n;
    cke_i = 1'b1; arst_n_i = 1'b0;
    config_in_addr_i = '0; config_in_length_i = '0; config_in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("awsize", 64'(awsize_o), 64'd2);
    chk("awburst", 64'(awburst_o), 64'd1);
    chk("awid", 64'(awid_o), 64'd0);
    chk("awlock", 64'(awlock_o), 64'd0);
    chk("awcache", 64'(awcache_o), 64'd2);
    chk("awqos", 64'(awqos_o), 64'd0);
    chk("wstrb", 64'(wstrb_o), 64'hF);
    @(posedge clk); #1;
    arst_n_i = 1'b1;

    // 40 words from 0: three bursts of 16, 16, 8
    push_burst(32'h0000_0000, 15);
    push_burst(32'h0000_0040, 15);
    push_burst(32'h0000_0080, 7);
    send_cmd(32'h0000_0000, 32'd40);
    wait_done("linear");

    // 8 words from 0xFF8: split at the 4 KiB boundary into 2 + 6
    push_burst(32'h0000_0FF8, 1);
    push_burst(32'h0000_1000, 5);
    send_cmd(32'h0000_0FF8, 32'd8);
    wait_done("page_split");

    // Zero length: nothing issued, stays ready
    @(posedge clk); #1;
    config_in_addr_i = 32'h100; config_in_length_i = '0; config_in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len0_cfg_ready", 64'(config_in_ready_o), 64'd1);
      chk("len0_awvalid", 64'(awvalid_o), 64'd0);
    end
    @(posedge clk); #1;
    config_in_valid_i = 1'b0;

    // Random stalls on every channel, 40 words from 0xF80: 16, 16 (to page end), 8
    stall_en = 1'b1;
    push_burst(32'h0000_0F80, 15);
    push_burst(32'h0000_0FC0, 15);
    push_burst(32'h0000_1000, 7);
    send_cmd(32'h0000_0F80, 32'd40);
    wait_done("stalled");
    stall_en = 1'b0;

    // Reset while waiting in DATA
    w_block = 1'b1;
    push_burst(32'h0000_2000, 15);
    push_burst(32'h0000_2040, 15);
    push_burst(32'h0000_2080, 7);
    n = aw_count;
    send_cmd(32'h0000_2000, 32'd40);
    for (int i = 0; i < 100 && aw_count == n; i++) @(negedge clk);
    chk("mid_aw_seen", 64'(aw_count), 64'(n + 1));
    repeat (3) @(posedge clk);
    #1;
    in_rst = 1'b1;
    arst_n_i = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    exp_aw.delete();
    exp_w.delete();
    repeat (2) @(posedge clk);
    #1;
    arst_n_i = 1'b1; in_rst = 1'b0; w_block = 1'b0;

    // Recovery after the abandoned transfer
    push_burst(32'h0000_0FF8, 1);
    push_burst(32'h0000_1000, 5);
    send_cmd(32'h0000_0FF8, 32'd8);
    wait_done("after_reset");

`ifdef IOB_AXIS2AXI_WR_ERR_EN
    // SLVERR on the first of three bursts: abort, sticky error, no further AW
    bresp_next = 2'b10;
    push_burst(32'h0000_3000, 15);
    send_cmd(32'h0000_3000, 32'd40);
    wait_done("err");
    chk("err_flag", 64'(error_o), 64'd1);
    chk("err_cfg_ready", 64'(config_in_ready_o), 64'd1);
    bresp_next = 2'b00;
    repeat (10) @(negedge clk);
    chk("err_sticky", 64'(error_o), 64'd1);
    chk("err_no_aw", 64'(awvalid_o), 64'd0);
    @(posedge clk); #1;
    in_rst = 1'b1; arst_n_i = 1'b0;
    #1;
    chk("err_cleared", 64'(error_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    arst_n_i = 1'b1; in_rst = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
